// File: rtl/elevator_pkg.sv
// Shared types, default sizes and floor helpers for the elevator scheduler.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS_DEF  = 4;
    localparam int unsigned FLOOR_W_DEF     = 2;
    localparam int unsigned WDOG_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    // Absolute distance between two floor indices
    function automatic int unsigned floor_dist(input int unsigned a, input int unsigned b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/elevator_target_sel.sv
// Combinational SCAN target selection from the latched calls and the car position.
module elevator_target_sel
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int unsigned FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    output logic [FLOOR_W-1:0]    above_o,
    output logic [FLOOR_W-1:0]    below_o,
    output logic                  has_above_o,
    output logic                  has_below_o,
    output logic                  nearest_dir_o,
    output logic [FLOOR_W-1:0]    nearest_o,
    output logic                  has_nearest_o
);

    logic [FLOOR_W-1:0] up_s;
    logic [FLOOR_W-1:0] dn_s;
    logic               has_up_s;
    logic               has_dn_s;
    int unsigned        dist_up;
    int unsigned        dist_dn;

    // Scan floors: inclusive above/below for travel, strict ones for the idle departure choice
    always_comb begin
        above_o     = '0;
        below_o     = '0;
        has_above_o = 1'b0;
        has_below_o = 1'b0;
        up_s        = '0;
        dn_s        = '0;
        has_up_s    = 1'b0;
        has_dn_s    = 1'b0;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (pending_i[f]) begin
                if (!has_above_o && (FLOOR_W'(f) >= current_floor_i)) begin
                    above_o     = FLOOR_W'(f);
                    has_above_o = 1'b1;
                end
                if (!has_up_s && (FLOOR_W'(f) > current_floor_i)) begin
                    up_s     = FLOOR_W'(f);
                    has_up_s = 1'b1;
                end
                if (FLOOR_W'(f) <= current_floor_i) begin
                    below_o     = FLOOR_W'(f);
                    has_below_o = 1'b1;
                end
                if (FLOOR_W'(f) < current_floor_i) begin
                    dn_s     = FLOOR_W'(f);
                    has_dn_s = 1'b1;
                end
            end
        end

        dist_up = floor_dist(32'(up_s), 32'(current_floor_i));
        dist_dn = floor_dist(32'(dn_s), 32'(current_floor_i));

        // Ties go upward
        if (has_up_s && (!has_dn_s || (dist_up <= dist_dn))) begin
            nearest_dir_o = 1'b1;
            nearest_o     = up_s;
        end else begin
            nearest_dir_o = 1'b0;
            nearest_o     = dn_s;
        end
        has_nearest_o = has_up_s | has_dn_s;
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: latches floor calls, drives the car's target floor.
// Optional stall watchdog enabled by defining ELEV_SCHED_WDOG_EN.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = NUM_FLOORS_DEF,
    parameter int unsigned FLOOR_W     = FLOOR_W_DEF
`ifdef ELEV_SCHED_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_FLOORS-1:0] call_req_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    input  logic                  door_open_i,
    output logic [FLOOR_W-1:0]    req_floor_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  dir_up_o,
    output logic                  dir_down_o
`ifdef ELEV_SCHED_WDOG_EN
    ,
    output logic                  wdog_fault_o
`endif
);

    logic [FLOOR_W-1:0]    cf;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    state_e                state_q;
    state_e                state_d;
    logic [FLOOR_W-1:0]    req_floor_q;
    logic [FLOOR_W-1:0]    req_floor_d;
    logic                  dir_up_q;
    logic                  dir_down_q;

    logic [FLOOR_W-1:0]    above;
    logic [FLOOR_W-1:0]    below;
    logic                  has_above;
    logic                  has_below;
    logic                  nearest_up;
    logic [FLOOR_W-1:0]    nearest;
    logic                  has_nearest;

    // Clamp floor reports beyond the top floor when the index space is wider than the building
    if ((1 << FLOOR_W) > NUM_FLOORS) begin : g_clamp
        assign cf = (current_floor_i > FLOOR_W'(NUM_FLOORS - 1)) ? FLOOR_W'(NUM_FLOORS - 1)
                                                                  : current_floor_i;
    end else begin : g_no_clamp
        assign cf = current_floor_i;
    end

    elevator_target_sel #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_target_sel (
        .pending_i       (pending_q),
        .current_floor_i (cf),
        .above_o         (above),
        .below_o         (below),
        .has_above_o     (has_above),
        .has_below_o     (has_below),
        .nearest_dir_o   (nearest_up),
        .nearest_o       (nearest),
        .has_nearest_o   (has_nearest)
    );

`ifdef ELEV_SCHED_WDOG_EN
    localparam int unsigned WCW = $clog2(WDOG_CYCLES + 1);

    logic [WCW-1:0]     wdog_cnt_q;
    logic [WCW-1:0]     wdog_cnt_d;
    logic [FLOOR_W-1:0] floor_q;
    logic               wdog_fault_q;
    logic               wdog_clr;
    logic               wdog_hit;

    // Stall detection: count cycles spent travelling with no floor change and no door activity
    always_comb begin
        wdog_clr   = (state_q == IDLE) || (cf != floor_q) || door_open_i;
        wdog_hit   = !wdog_clr && (wdog_cnt_q == WCW'(WDOG_CYCLES - 1));
        wdog_cnt_d = wdog_clr ? '0 : wdog_cnt_q + WCW'(1);
    end

    // Watchdog counter, last-floor tracker and sticky fault flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_cnt_q   <= '0;
            floor_q      <= '0;
            wdog_fault_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            floor_q      <= cf;
            wdog_fault_q <= wdog_fault_q | wdog_hit;
        end
    end

    assign wdog_fault_o = wdog_fault_q;
`endif

    // Call latch: serving a floor wins over a same-cycle press of that floor
    always_comb begin
        pending_d = pending_q;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (door_open_i && (cf == FLOOR_W'(f))) begin
                pending_d[f] = 1'b0;
            end else if (call_req_i[f]) begin
                pending_d[f] = 1'b1;
            end
        end
    end

    // SCAN next-state and target selection
    always_comb begin
        state_d     = state_q;
        req_floor_d = req_floor_q;
        unique case (state_q)
            IDLE: begin
                if (has_nearest) begin
                    state_d     = nearest_up ? UP : DOWN;
                    req_floor_d = nearest;
                end else begin
                    state_d     = IDLE;
                    req_floor_d = cf;
                end
            end
            UP: begin
                if (has_above) begin
                    state_d     = UP;
                    req_floor_d = above;
                end else if (has_below) begin
                    state_d     = DOWN;
                    req_floor_d = below;
                end else begin
                    state_d     = IDLE;
                    req_floor_d = cf;
                end
            end
            DOWN: begin
                if (has_below) begin
                    state_d     = DOWN;
                    req_floor_d = below;
                end else if (has_above) begin
                    state_d     = UP;
                    req_floor_d = above;
                end else begin
                    state_d     = IDLE;
                    req_floor_d = cf;
                end
            end
            default: begin
                state_d     = IDLE;
                req_floor_d = cf;
            end
        endcase
`ifdef ELEV_SCHED_WDOG_EN
        // A tripped watchdog parks the car where it is; calls keep latching
        if (wdog_fault_q || wdog_hit) begin
            state_d     = IDLE;
            req_floor_d = cf;
        end
`endif
    end

    // FSM state, call latch and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            state_q     <= IDLE;
            req_floor_q <= '0;
            dir_up_q    <= 1'b0;
            dir_down_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            state_q     <= state_d;
            req_floor_q <= req_floor_d;
            dir_up_q    <= (state_d == UP);
            dir_down_q  <= (state_d == DOWN);
        end
    end

    assign req_floor_o = req_floor_q;
    assign pending_o   = pending_q;
    assign dir_up_o    = dir_up_q;
    assign dir_down_o  = dir_down_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a simple car model
// (1 floor per 2 cycles, door open 2 cycles when stopped at a pending target).
// Watchdog steps are included when ELEV_SCHED_WDOG_EN is defined.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] call_req = 4'b0000;
    logic [1:0] current_floor = 2'd0;
    logic       door_open = 1'b0;
    logic [1:0] req_floor_o;
    logic [3:0] pending_o;
    logic       dir_up_o;
    logic       dir_down_o;
`ifdef ELEV_SCHED_WDOG_EN
    logic       wdog_fault_o;
`endif

    // Car model state and manual override
    logic       car_auto = 1'b1;
    logic [1:0] man_floor = 2'd0;
    logic       man_door = 1'b0;
    logic [1:0] car_floor = 2'd0;
    int         mv_cnt = 0;
    int         door_cnt = 0;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       overlap_seen = 1'b0;

    elevator_scheduler dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .call_req_i      (call_req),
        .current_floor_i (current_floor),
        .door_open_i     (door_open),
        .req_floor_o     (req_floor_o),
        .pending_o       (pending_o),
        .dir_up_o        (dir_up_o),
        .dir_down_o      (dir_down_o)
`ifdef ELEV_SCHED_WDOG_EN
        ,
        .wdog_fault_o    (wdog_fault_o)
`endif
    );

    always #5 clk = ~clk;

    // Car reacts shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (!car_auto) begin
            car_floor     = man_floor;
            mv_cnt        = 0;
            door_cnt      = 0;
            current_floor = man_floor;
            door_open     = man_door;
        end else begin
            if (door_cnt != 0) begin
                door_cnt = door_cnt - 1;
            end else if (car_floor != req_floor_o) begin
                mv_cnt = mv_cnt + 1;
                if (mv_cnt == 2) begin
                    mv_cnt    = 0;
                    car_floor = (car_floor < req_floor_o) ? 2'(car_floor + 2'd1)
                                                          : 2'(car_floor - 2'd1);
                end
            end else begin
                mv_cnt = 0;
                if (pending_o[car_floor]) door_cnt = 2;
            end
            current_floor = car_floor;
            door_open     = (door_cnt != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (dir_up_o && dir_down_o) overlap_seen = 1'b1;
    endtask

    task automatic press(input logic [3:0] mask);
        call_req = mask;
        tick();
        call_req = 4'b0000;
    endtask

    task automatic wait_door(input logic [1:0] f, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (door_open && (current_floor == f)) found = 1'b1;
            else tick();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_pending", 32'(pending_o), 32'h0);
        chk("rst_req", 32'(req_floor_o), 32'h0);
        chk("rst_up", 32'(dir_up_o), 32'h0);
        chk("rst_down", 32'(dir_down_o), 32'h0);

        // 1: single call to the top floor from floor 0
        press(4'b1000);
        chk("t1_pending", 32'(pending_o), 32'h8);
        chk("t1_idle_up", 32'(dir_up_o), 32'h0);
        tick();
        chk("t1_up", 32'(dir_up_o), 32'h1);
        chk("t1_req", 32'(req_floor_o), 32'h3);
        chk("t1_down", 32'(dir_down_o), 32'h0);
        wait_door(2'd3, 40, "t1_arrive3");
        chk("t1_pend_at_door", 32'(pending_o), 32'h8);
        tick();
        chk("t1_cleared", 32'(pending_o), 32'h0);
        chk("t1_still_up", 32'(dir_up_o), 32'h1);
        tick();
        chk("t1_idle", 32'(dir_up_o), 32'h0);
        chk("t1_idle_req", 32'(req_floor_o), 32'h3);

        // 2: move car to 1, then intercept a floor-2 call while heading to 3
        press(4'b0010);
        wait_door(2'd1, 40, "t2_arrive1");
        settle();
        chk("t2_setup_req", 32'(req_floor_o), 32'h1);
        chk("t2_setup_down", 32'(dir_down_o), 32'h0);
        press(4'b1000);
        tick();
        chk("t2_up", 32'(dir_up_o), 32'h1);
        chk("t2_req3", 32'(req_floor_o), 32'h3);
        press(4'b0100);
        chk("t2_pending", 32'(pending_o), 32'hC);
        chk("t2_req3b", 32'(req_floor_o), 32'h3);
        tick();
        chk("t2_req2", 32'(req_floor_o), 32'h2);
        chk("t2_up2", 32'(dir_up_o), 32'h1);
        wait_door(2'd2, 4, "t2_stop2");
        tick();
        chk("t2_clr2", 32'(pending_o), 32'h8);
        tick();
        chk("t2_resume3", 32'(req_floor_o), 32'h3);
        chk("t2_resume_up", 32'(dir_up_o), 32'h1);
        wait_door(2'd3, 40, "t2_arrive3");
        settle();
        chk("t2_done_pend", 32'(pending_o), 32'h0);
        chk("t2_done_up", 32'(dir_up_o), 32'h0);

        // 3: going up past 2 with calls at 0 and 3: top first, then reverse
        overlap_seen = 1'b0;
        press(4'b0010);
        wait_door(2'd1, 40, "t3_arrive1");
        settle();
        press(4'b1000);
        tick();
        chk("t3_req3", 32'(req_floor_o), 32'h3);
        tick();
        press(4'b0001);
        chk("t3_pending", 32'(pending_o), 32'h9);
        chk("t3_up", 32'(dir_up_o), 32'h1);
        chk("t3_req3b", 32'(req_floor_o), 32'h3);
        wait_door(2'd3, 20, "t3_arrive3");
        chk("t3_up_at3", 32'(dir_up_o), 32'h1);
        tick();
        chk("t3_clr3", 32'(pending_o), 32'h1);
        tick();
        chk("t3_down", 32'(dir_down_o), 32'h1);
        chk("t3_req0", 32'(req_floor_o), 32'h0);
        chk("t3_not_up", 32'(dir_up_o), 32'h0);
        wait_door(2'd0, 40, "t3_arrive0");
        settle();
        chk("t3_idle_down", 32'(dir_down_o), 32'h0);
        chk("t3_done_pend", 32'(pending_o), 32'h0);
        chk("t3_idle_req", 32'(req_floor_o), 32'h0);
        chk("t3_no_overlap", 32'(overlap_seen), 32'h0);

        // 4: idle at 1, simultaneous calls at 0 and 3: nearer floor 0 wins
        press(4'b0010);
        wait_door(2'd1, 40, "t4_arrive1");
        settle();
        press(4'b1001);
        chk("t4_pending", 32'(pending_o), 32'h9);
        chk("t4_idle", 32'(dir_down_o), 32'h0);
        tick();
        chk("t4_down", 32'(dir_down_o), 32'h1);
        chk("t4_req0", 32'(req_floor_o), 32'h0);
        chk("t4_not_up", 32'(dir_up_o), 32'h0);
        wait_door(2'd0, 40, "t4_arrive0");
        tick();
        chk("t4_clr0", 32'(pending_o), 32'h8);
        tick();
        chk("t4_reverse_up", 32'(dir_up_o), 32'h1);
        chk("t4_req3", 32'(req_floor_o), 32'h3);
        wait_door(2'd3, 40, "t4_arrive3");
        settle();
        chk("t4_done_pend", 32'(pending_o), 32'h0);

        // 5: press at the floor being served is absorbed, other floor latches
        car_auto  = 1'b0;
        man_floor = 2'd2;
        man_door  = 1'b0;
        tick();
        man_door = 1'b1;
        tick();
        press(4'b0110);
        man_door = 1'b0;
        chk("t5_absorb", 32'(pending_o), 32'h2);
        chk("t5_idle_req", 32'(req_floor_o), 32'h2);
        chk("t5_idle", 32'(dir_down_o), 32'h0);
        tick();
        chk("t5_down", 32'(dir_down_o), 32'h1);
        chk("t5_req1", 32'(req_floor_o), 32'h1);

        // 6: asynchronous reset mid-travel
        #2;
        rst = 1'b1;
        #1;
        chk("t6_pending", 32'(pending_o), 32'h0);
        chk("t6_req", 32'(req_floor_o), 32'h0);
        chk("t6_down", 32'(dir_down_o), 32'h0);
        chk("t6_up", 32'(dir_up_o), 32'h0);
        man_floor = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_after_pend", 32'(pending_o), 32'h0);

`ifdef ELEV_SCHED_WDOG_EN
        // Watchdog: car frozen at 0 while dispatched upward
        chk("wd_clear", 32'(wdog_fault_o), 32'h0);
        press(4'b1000);
        tick();
        chk("wd_up", 32'(dir_up_o), 32'h1);
        repeat (63) tick();
        chk("wd_not_yet", 32'(wdog_fault_o), 32'h0);
        chk("wd_still_up", 32'(dir_up_o), 32'h1);
        tick();
        chk("wd_fault", 32'(wdog_fault_o), 32'h1);
        chk("wd_forced_idle", 32'(dir_up_o), 32'h0);
        chk("wd_req_cf", 32'(req_floor_o), 32'h0);
        press(4'b0010);
        chk("wd_latch", 32'(pending_o), 32'hA);
        tick();
        chk("wd_no_dispatch_up", 32'(dir_up_o), 32'h0);
        chk("wd_no_dispatch_dn", 32'(dir_down_o), 32'h0);
        chk("wd_sticky", 32'(wdog_fault_o), 32'h1);
`endif

        chk("no_overlap_end", 32'(overlap_seen), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
